// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor: state encoding,
// default timing parameters and the cycle-counter width helper.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam int DEF_SYNC_STAGES           = 2;
    localparam int DEF_PLL_RST_PULSE_CYCLES  = 8;
    localparam int DEF_RELOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_LOCK_STABLE_CYCLES    = 1024;
    localparam int DEF_RESET_HOLD_CYCLES     = 16;
    localparam int DEF_LOSS_CNT_W            = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // The counter only ever needs to reach N-1 of the longest timed state.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = max4(a, b, c, d);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_PLL_RST_PULSE_CYCLES, DEF_RELOCK_TIMEOUT_CYCLES,
                                         DEF_LOCK_STABLE_CYCLES, DEF_RESET_HOLD_CYCLES);

endpackage

// File: rtl/bit_sync.sv
// Multi-flop single-bit synchroniser for asynchronous status inputs.
// Flops clear to 0 under the synchronous reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer on the free-running reference clock: pulses the PLL
// reset, qualifies lock, releases the system reset and re-arms on lock loss.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES           = DEF_SYNC_STAGES,
    parameter int PLL_RST_PULSE_CYCLES  = DEF_PLL_RST_PULSE_CYCLES,
    parameter int RELOCK_TIMEOUT_CYCLES = DEF_RELOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES    = DEF_LOCK_STABLE_CYCLES,
    parameter int RESET_HOLD_CYCLES     = DEF_RESET_HOLD_CYCLES,
    parameter int LOSS_CNT_W            = DEF_LOSS_CNT_W
) (
    input  logic                  i_refclk,
    input  logic                  i_rst,
    input  logic                  i_pll_locked_async,
    output logic                  o_pll_rst,
    output logic                  o_sys_rst,
    output logic                  o_lock_ok,
    output logic [LOSS_CNT_W-1:0] o_loss_count,
    output logic                  o_timeout_err
);

    localparam int CNT_W = cnt_width(PLL_RST_PULSE_CYCLES, RELOCK_TIMEOUT_CYCLES,
                                     LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);

    localparam logic [CNT_W-1:0] C_PULSE_LAST   = CNT_W'(PLL_RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(RELOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_lk;
    logic             w_timeout;
    logic             w_loss;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .i_clk(i_refclk),
        .i_rst(i_rst),
        .i_d  (i_pll_locked_async),
        .o_q  (w_lk)
    );

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_loss    = 1'b0;
        case (r_state)
            PLL_RST: begin
                if (r_count == C_PULSE_LAST) w_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_lk) begin
                    w_next = STABLE;
                end else if (r_count == C_TIMEOUT_LAST) begin
                    w_next    = PLL_RST;
                    w_timeout = 1'b1;
                end
            end
            STABLE: begin
                if (!w_lk) w_next = WAIT_LOCK;
                else if (r_count == C_STABLE_LAST) w_next = HOLD;
            end
            HOLD: begin
                if (!w_lk) w_next = WAIT_LOCK;
                else if (r_count == C_HOLD_LAST) w_next = RUN;
            end
            RUN: begin
                if (!w_lk) begin
                    w_next = PLL_RST;
                    w_loss = 1'b1;
                end
            end
            default: w_next = PLL_RST;
        endcase
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the transition itself. The counter free-runs in RUN.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state       <= PLL_RST;
            r_count       <= '0;
            o_pll_rst     <= 1'b1;
            o_sys_rst     <= 1'b1;
            o_lock_ok     <= 1'b0;
            o_loss_count  <= '0;
            o_timeout_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_count   <= (w_next != r_state) ? '0 : r_count + CNT_W'(1);
            o_pll_rst <= (w_next == PLL_RST);
            o_sys_rst <= (w_next != RUN);
            o_lock_ok <= (w_next == RUN);
            if (w_timeout) o_timeout_err <= 1'b1;
            if (w_loss && (o_loss_count != '1)) o_loss_count <= o_loss_count + LOSS_CNT_W'(1);
        end
    end

endmodule
